nts_ntp_header_parser: RTL and testbench

- RX-side counterpart of the NTP header generator: consumes the 48-byte NTP header of a received client request, 64 bits per word, and drives the parser-side controls of nts_timestamp.
- Outputs: record_receive, transmit, origin timestamp, version and poll.
- Sits between the RX UDP payload extractor and nts_timestamp.
- Validates mode and version; drops short or bad frames with a clear pulse.

---
 rtl/nts_ntp_header_parser.sv | 171 +++++++++++++++++
 tb/tb_nts_ntp_header_parser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nts_ntp_header_parser.sv
// rtl/nts_ntp_header_parser.sv - NTP client request header parser driving nts_timestamp controls
// Optional frame counters are built when NTS_PARSER_COUNTERS_EN is defined.

module nts_ntp_header_parser #(
    parameter int MIN_VN = 3,
    parameter int MAX_VN = 4
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_rx_start,
    input  logic        i_rx_valid,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_last,
    input  logic        i_rx_bad,
    input  logic        i_tx_busy,
    output logic        o_parser_clear,
    output logic        o_parser_record_receive_timestamp,
    output logic        o_parser_transmit,
    output logic [63:0] o_parser_origin_timestamp,
    output logic [2:0]  o_parser_version_number,
    output logic [7:0]  o_parser_poll,
    output logic [31:0] o_good_count,
    output logic [31:0] o_drop_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR       = 3'd1,
        WAIT_LAST = 3'd2,
        PEND      = 3'd3,
        DISCARD   = 3'd4
    } state_t;

    localparam logic [2:0] MIN_VN_L = 3'(MIN_VN);
    localparam logic [2:0] MAX_VN_L = 3'(MAX_VN);

    state_t     state;
    logic [2:0] word_cnt;
    logic [2:0] vn_q;
    logic [2:0] mode_q;
    logic [7:0] poll_q;
    logic       rr_pend;
    logic       start;
    logic       frame_ok;

    always_comb begin
        start    = i_rx_valid & i_rx_start;
        frame_ok = (mode_q == 3'd3) && (vn_q >= MIN_VN_L) && (vn_q <= MAX_VN_L) && !i_rx_bad;
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state                             <= IDLE;
            word_cnt                          <= 3'd0;
            vn_q                              <= 3'd0;
            mode_q                            <= 3'd0;
            poll_q                            <= 8'd0;
            rr_pend                           <= 1'b0;
            o_parser_clear                    <= 1'b0;
            o_parser_record_receive_timestamp <= 1'b0;
            o_parser_transmit                 <= 1'b0;
            o_parser_origin_timestamp         <= 64'd0;
            o_parser_version_number           <= 3'd0;
            o_parser_poll                     <= 8'd0;
        end else begin
            o_parser_clear                    <= 1'b0;
            o_parser_transmit                 <= 1'b0;
            o_parser_record_receive_timestamp <= rr_pend;
            rr_pend                           <= 1'b0;
            // A restarted frame publishes its word 0 fields only after the clear cycle.
            if (rr_pend) begin
                o_parser_version_number <= vn_q;
                o_parser_poll           <= poll_q;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        vn_q                              <= i_rx_data[61:59];
                        mode_q                            <= i_rx_data[58:56];
                        poll_q                            <= i_rx_data[47:40];
                        o_parser_version_number           <= i_rx_data[61:59];
                        o_parser_poll                     <= i_rx_data[47:40];
                        o_parser_origin_timestamp         <= 64'd0;
                        o_parser_record_receive_timestamp <= 1'b1;
                        word_cnt                          <= 3'd1;
                        state                             <= i_rx_last ? DISCARD : HDR;
                    end
                end

                HDR, WAIT_LAST, PEND: begin
                    if (start) begin
                        vn_q                      <= i_rx_data[61:59];
                        mode_q                    <= i_rx_data[58:56];
                        poll_q                    <= i_rx_data[47:40];
                        o_parser_version_number   <= 3'd0;
                        o_parser_poll             <= 8'd0;
                        o_parser_origin_timestamp <= 64'd0;
                        o_parser_clear            <= 1'b1;
                        rr_pend                   <= 1'b1;
                        word_cnt                  <= 3'd1;
                        state                     <= i_rx_last ? DISCARD : HDR;
                    end else if (state == PEND) begin
                        if (!i_tx_busy) begin
                            o_parser_transmit <= 1'b1;
                            state             <= IDLE;
                        end
                    end else if (i_rx_valid) begin
                        word_cnt <= (word_cnt == 3'd7) ? 3'd7 : word_cnt + 3'd1;
                        if (state == HDR && word_cnt == 3'd5) begin
                            o_parser_origin_timestamp <= i_rx_data;
                        end
                        if (i_rx_last) begin
                            if (state == HDR && word_cnt < 3'd5) begin
                                state <= DISCARD;
                            end else if (!frame_ok) begin
                                state <= DISCARD;
                            end else if (i_tx_busy) begin
                                state <= PEND;
                            end else begin
                                o_parser_transmit <= 1'b1;
                                state             <= IDLE;
                            end
                        end else if (state == HDR && word_cnt == 3'd5) begin
                            state <= WAIT_LAST;
                        end
                    end
                end

                DISCARD: begin
                    // Hold off the clear until a pending record_receive pulse has gone out.
                    if (!rr_pend) begin
                        o_parser_clear            <= 1'b1;
                        o_parser_version_number   <= 3'd0;
                        o_parser_poll             <= 8'd0;
                        o_parser_origin_timestamp <= 64'd0;
                        state                     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef NTS_PARSER_COUNTERS_EN
    logic [31:0] good_count_q;
    logic [31:0] drop_count_q;

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            good_count_q <= 32'd0;
            drop_count_q <= 32'd0;
        end else begin
            if (o_parser_transmit) begin
                good_count_q <= good_count_q + 32'd1;
            end
            if (o_parser_clear) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    assign o_good_count = good_count_q;
    assign o_drop_count = drop_count_q;
`else
    assign o_good_count = 32'd0;
    assign o_drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_nts_ntp_header_parser.sv
// tb/tb_nts_ntp_header_parser.sv - table-driven bench for nts_ntp_header_parser

module tb_nts_ntp_header_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_start;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic        rx_last;
    logic        rx_bad;
    logic        tx_busy;
    logic        clear;
    logic        rr;
    logic        tx;
    logic [63:0] origin;
    logic [2:0]  vn;
    logic [7:0]  poll;
    logic [31:0] good_count;
    logic [31:0] drop_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nts_ntp_header_parser #(.MIN_VN(3), .MAX_VN(4)) dut (
        .i_clk                             (clk),
        .i_areset                          (rst),
        .i_rx_start                        (rx_start),
        .i_rx_valid                        (rx_valid),
        .i_rx_data                         (rx_data),
        .i_rx_last                         (rx_last),
        .i_rx_bad                          (rx_bad),
        .i_tx_busy                         (tx_busy),
        .o_parser_clear                    (clear),
        .o_parser_record_receive_timestamp (rr),
        .o_parser_transmit                 (tx),
        .o_parser_origin_timestamp         (origin),
        .o_parser_version_number           (vn),
        .o_parser_poll                     (poll),
        .o_good_count                      (good_count),
        .o_drop_count                      (drop_count)
    );

    typedef struct {
        logic        rst, st, vl;
        logic [63:0] d;
        logic        ls, bd, bz;
        logic        ec, er, et;
        logic [63:0] eo;
        logic [2:0]  ev;
        logic [7:0]  ep;
        logic        cnt_chk;
        logic [31:0] eg, edr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] W0A = 64'h23000a0000000000;
    localparam logic [63:0] W0M = 64'h24000a0000000000;
    localparam logic [63:0] W0V = 64'h13000a0000000000;
    localparam logic [63:0] W0B = 64'h1b00060000000000;
    localparam logic [63:0] W5A = 64'hffffdddd00000001;
    localparam logic [63:0] W5B = 64'h0123456789abcdef;

    task automatic add(input logic r, s, v, input logic [63:0] d, input logic l, b, z,
                       input logic ec, er, et, input logic [63:0] eo,
                       input logic [2:0] ev, input logic [7:0] ep);
        vec_t x;
        x.rst = r; x.st = s; x.vl = v; x.d = d; x.ls = l; x.bd = b; x.bz = z;
        x.ec = ec; x.er = er; x.et = et; x.eo = eo; x.ev = ev; x.ep = ep;
        x.cnt_chk = 1'b0; x.eg = 32'd0; x.edr = 32'd0;
        vecs.push_back(x);
    endtask

    task automatic mid(input logic [63:0] d, input logic [63:0] eo, input logic [2:0] ev,
                       input logic [7:0] ep);
        add(0, 0, 1, d, 0, 0, 0, 0, 0, 0, eo, ev, ep);
    endtask

    task automatic cnt(input logic [31:0] g, input logic [31:0] dr);
`ifdef NTS_PARSER_COUNTERS_EN
        vecs[vecs.size()-1].eg  = g;
        vecs[vecs.size()-1].edr = dr;
`else
        vecs[vecs.size()-1].eg  = g & 32'd0;
        vecs[vecs.size()-1].edr = dr & 32'd0;
`endif
        vecs[vecs.size()-1].cnt_chk = 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, v, input logic [63:0] d, input logic l, b, z);
        rst = r; rx_start = s; rx_valid = v; rx_data = d; rx_last = l; rx_bad = b; tx_busy = z;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 64'd0, 0, 0, 0);

        // Reset, then words that must be ignored in IDLE
        add(1, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        add(0, 1, 0, W0A,   0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 1, W0A,   1, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        cnt(0, 0);
        // Valid request with an invalid-word gap inside the header
        add(0, 1, 1, W0A, 0, 0, 0, 0, 1, 0, 64'd0, 4, 8'h0a);
        mid(64'h1111, 64'd0, 4, 8'h0a);
        mid(64'h2222, 64'd0, 4, 8'h0a);
        add(0, 1, 0, 64'h9999, 1, 1, 0, 0, 0, 0, 64'd0, 4, 8'h0a);
        mid(64'h3333, 64'd0, 4, 8'h0a);
        mid(64'h4444, 64'd0, 4, 8'h0a);
        add(0, 0, 1, W5A, 1, 0, 0, 0, 0, 1, W5A, 4, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, W5A, 4, 8'h0a);
        cnt(1, 0);
        // Short frame: last on word 3
        add(0, 1, 1, W0A, 0, 0, 0, 0, 1, 0, 64'd0, 4, 8'h0a);
        mid(64'h1111, 64'd0, 4, 8'h0a);
        mid(64'h2222, 64'd0, 4, 8'h0a);
        add(0, 0, 1, 64'h3333, 1, 0, 0, 0, 0, 0, 64'd0, 4, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 0, 1, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        cnt(1, 1);
        // Mode 4
        add(0, 1, 1, W0M, 0, 0, 0, 0, 1, 0, 64'd0, 4, 8'h0a);
        for (int i = 1; i < 5; i++) mid(64'(i), 64'd0, 4, 8'h0a);
        add(0, 0, 1, W5A, 1, 0, 0, 0, 0, 0, W5A, 4, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 0, 1, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        // VN 2
        add(0, 1, 1, W0V, 0, 0, 0, 0, 1, 0, 64'd0, 2, 8'h0a);
        for (int i = 1; i < 5; i++) mid(64'(i), 64'd0, 2, 8'h0a);
        add(0, 0, 1, W5A, 1, 0, 0, 0, 0, 0, W5A, 2, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 0, 1, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        cnt(1, 3);
        // Three extension words, last on word 8, busy high for 5 cycles
        add(0, 1, 1, W0A, 0, 0, 0, 0, 1, 0, 64'd0, 4, 8'h0a);
        for (int i = 1; i < 5; i++) mid(64'(i), 64'd0, 4, 8'h0a);
        mid(W5A, W5A, 4, 8'h0a);
        mid(64'h6666, W5A, 4, 8'h0a);
        mid(64'h7777, W5A, 4, 8'h0a);
        add(0, 0, 1, 64'h8888, 1, 0, 1, 0, 0, 0, W5A, 4, 8'h0a);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 64'd0, 0, 0, 1, 0, 0, 0, W5A, 4, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, W5A, 4, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, W5A, 4, 8'h0a);
        cnt(2, 3);
        // rx_bad on the last word
        add(0, 1, 1, W0A, 0, 0, 0, 0, 1, 0, 64'd0, 4, 8'h0a);
        for (int i = 1; i < 5; i++) mid(64'(i), 64'd0, 4, 8'h0a);
        add(0, 0, 1, W5A, 1, 1, 0, 0, 0, 0, W5A, 4, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 0, 1, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        // Restart in HDR: clear, then record_receive, then second frame replies
        add(0, 1, 1, W0A, 0, 0, 0, 0, 1, 0, 64'd0, 4, 8'h0a);
        mid(64'h1111, 64'd0, 4, 8'h0a);
        mid(64'h2222, 64'd0, 4, 8'h0a);
        add(0, 1, 1, W0B, 0, 0, 0, 1, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 1, 64'h1111, 0, 0, 0, 0, 1, 0, 64'd0, 3, 8'h06);
        for (int i = 2; i < 5; i++) mid(64'(i), 64'd0, 3, 8'h06);
        add(0, 0, 1, W5B, 1, 0, 0, 0, 0, 1, W5B, 3, 8'h06);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, W5B, 3, 8'h06);
        cnt(3, 5);
        // Reset while in PEND
        add(0, 1, 1, W0A, 0, 0, 0, 0, 1, 0, 64'd0, 4, 8'h0a);
        for (int i = 1; i < 5; i++) mid(64'(i), 64'd0, 4, 8'h0a);
        add(0, 0, 1, W5A, 1, 0, 1, 0, 0, 0, W5A, 4, 8'h0a);
        add(0, 0, 0, 64'd0, 0, 0, 1, 0, 0, 0, W5A, 4, 8'h0a);
        add(1, 0, 0, 64'd0, 0, 0, 1, 0, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        add(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 8'h00);
        cnt(0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].vl, vecs[i].d, vecs[i].ls, vecs[i].bd, vecs[i].bz);
            step();
            chk($sformatf("v%0d clear", i),  64'(clear),  64'(vecs[i].ec));
            chk($sformatf("v%0d rr", i),     64'(rr),     64'(vecs[i].er));
            chk($sformatf("v%0d tx", i),     64'(tx),     64'(vecs[i].et));
            chk($sformatf("v%0d origin", i), origin,      vecs[i].eo);
            chk($sformatf("v%0d vn", i),     64'(vn),     64'(vecs[i].ev));
            chk($sformatf("v%0d poll", i),   64'(poll),   64'(vecs[i].ep));
            if (vecs[i].cnt_chk) begin
                chk($sformatf("v%0d good_count", i), 64'(good_count), 64'(vecs[i].eg));
                chk($sformatf("v%0d drop_count", i), 64'(drop_count), 64'(vecs[i].edr));
            end
        end

`ifdef NTS_PARSER_COUNTERS_EN
        begin
            int tx_seen;
            tx_seen = 0;
            drive(0, 0, 0, 64'd0, 0, 0, 0);
            force dut.good_count_q = 32'hffffffff;
            step();
            release dut.good_count_q;
            #1;
            chk("wrap preset", 64'(good_count), 64'hffffffff);
            for (int w = 0; w < 6; w++) begin
                drive(0, w == 0, 1, (w == 0) ? W0A : ((w == 5) ? W5A : 64'(w)), w == 5, 0, 0);
                step();
                tx_seen += int'(tx);
            end
            drive(0, 0, 0, 64'd0, 0, 0, 0);
            step();
            tx_seen += int'(tx);
            chk("wrap tx pulses", 64'(tx_seen), 64'd1);
            chk("wrap good_count", 64'(good_count), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
